// File: rtl/rom_read_arbiter_pkg.sv
// Shared definitions for the two-client ROM read arbiter: widths, FSM encodings
// and the access-counter load helper.
package rom_read_arbiter_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 4;
    localparam int CNT_W      = 4;

    // Encoding 2'd3 is unused and recovers to idle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter preload for a given access length, clamped to 1..15 cycles so an
    // out-of-range override can never make the counter wrap.
    function automatic cnt_t access_load(input int access_cyc);
        if (access_cyc < 1) begin
            return cnt_t'(0);
        end else if (access_cyc > 15) begin
            return cnt_t'(14);
        end else begin
            return cnt_t'(access_cyc - 1);
        end
    endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: with both requesting, the one that
// was not granted last wins; a single requester always wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational ROM between two requesters: round-robin grant, hold
// address/rd for ACCESS_CYC cycles, register the word, then a 1-cycle ack.
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int ACCESS_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_out
);

    localparam cnt_t CNT_LOAD = access_load(ACCESS_CYC);

    logic [1:0]        state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              winner_q, winner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              rom_rd_q, rom_rd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;

    logic gnt_valid;
    logic gnt_id;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        winner_d      = winner_q;
        last_gnt_d    = last_gnt_q;
        rom_address_d = rom_address_q;
        rom_rd_d      = rom_rd_q;
        rdata_d       = rdata_q;
        busy_d        = busy_q;
        ack_d         = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    winner_d      = gnt_id;
                    rom_address_d = gnt_id ? addr1 : addr0;
                    rom_rd_d      = 1'b1;
                    cnt_d         = CNT_LOAD;
                    busy_d        = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Fairness only advances once the read actually completes.
                    rdata_d          = rom_out;
                    rom_rd_d         = 1'b0;
                    ack_d[winner_q]  = 1'b1;
                    last_gnt_d       = winner_q;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                rom_rd_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            winner_q      <= 1'b0;
            last_gnt_q    <= 1'b1;
            rom_address_q <= '0;
            rom_rd_q      <= 1'b0;
            rdata_q       <= '0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            winner_q      <= winner_d;
            last_gnt_q    <= last_gnt_d;
            rom_address_q <= rom_address_d;
            rom_rd_q      <= rom_rd_d;
            rdata_q       <= rdata_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
        end
    end

    assign ack0        = ack_q[0];
    assign ack1        = ack_q[1];
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign rom_address = rom_address_q;
    assign rom_rd      = rom_rd_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: two instances (1-cycle and 4-cycle access) on a
// shared ROM table, a timeline model checked every cycle, plus directed cases.
module tb_rom_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       req0_a, req1_a, ack0_a, ack1_a, busy_a, rom_rd_a;
    logic [3:0] addr0_a, addr1_a, rdata_a, rom_address_a, rom_out_a;
    logic       req0_b, req1_b, ack0_b, ack1_b, busy_b, rom_rd_b;
    logic [3:0] addr0_b, addr1_b, rdata_b, rom_address_b, rom_out_b;

    logic [3:0] rom [16];
    assign rom_out_a = rom[rom_address_a];
    assign rom_out_b = rom[rom_address_b];

    rom_read_arbiter #(.ADDR_W(4), .DATA_W(4), .ACCESS_CYC(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0_a), .addr0(addr0_a), .req1(req1_a), .addr1(addr1_a),
        .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .busy(busy_a),
        .rom_address(rom_address_a), .rom_rd(rom_rd_a), .rom_out(rom_out_a)
    );

    rom_read_arbiter #(.ADDR_W(4), .DATA_W(4), .ACCESS_CYC(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .addr0(addr0_b), .req1(req1_b), .addr1(addr1_b),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .busy(busy_b),
        .rom_address(rom_address_b), .rom_rd(rom_rd_b), .rom_out(rom_out_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = cycles since the grant edge (-1 when idle). A read holds rd
    // for ac cycles, then shows the ack for one cycle, then one idle cycle.
    int         pos [2];
    int         win [2];
    int         last [2];
    logic [3:0] e_addr [2];
    logic [3:0] e_rdata [2];

    function automatic int ac(input int k);
        return (k == 0) ? 1 : 4;
    endfunction
    function automatic logic in_req0(input int k);
        return (k == 0) ? req0_a : req0_b;
    endfunction
    function automatic logic in_req1(input int k);
        return (k == 0) ? req1_a : req1_b;
    endfunction
    function automatic logic [3:0] in_addr0(input int k);
        return (k == 0) ? addr0_a : addr0_b;
    endfunction
    function automatic logic [3:0] in_addr1(input int k);
        return (k == 0) ? addr1_a : addr1_b;
    endfunction

    task automatic model_step(input int k);
        if (rst) begin
            pos[k]     = -1;
            last[k]    = 1;
            e_addr[k]  = 4'h0;
            e_rdata[k] = 4'h0;
        end else if (pos[k] < 0) begin
            if (in_req0(k) || in_req1(k)) begin
                if (in_req0(k) && in_req1(k)) win[k] = 1 - last[k];
                else                          win[k] = in_req1(k) ? 1 : 0;
                e_addr[k] = (win[k] == 1) ? in_addr1(k) : in_addr0(k);
                pos[k]    = 0;
            end
        end else begin
            pos[k] = pos[k] + 1;
            if (pos[k] == ac(k)) begin
                e_rdata[k] = rom[e_addr[k]];
                last[k]    = win[k];
            end else if (pos[k] > ac(k)) begin
                pos[k] = -1;
            end
        end
    endtask

    task automatic compare(input int k);
        logic x_busy, x_rd, x_ack0, x_ack1;
        x_busy = (pos[k] >= 0);
        x_rd   = (pos[k] >= 0) && (pos[k] < ac(k));
        x_ack0 = (pos[k] == ac(k)) && (win[k] == 0);
        x_ack1 = (pos[k] == ac(k)) && (win[k] == 1);
        chk($sformatf("dut%0d_busy", k), (k == 0) ? busy_a : busy_b, x_busy);
        chk($sformatf("dut%0d_rom_rd", k), (k == 0) ? rom_rd_a : rom_rd_b, x_rd);
        chk($sformatf("dut%0d_ack0", k), (k == 0) ? ack0_a : ack0_b, x_ack0);
        chk($sformatf("dut%0d_ack1", k), (k == 0) ? ack1_a : ack1_b, x_ack1);
        chk($sformatf("dut%0d_rom_address", k), (k == 0) ? rom_address_a : rom_address_b, e_addr[k]);
        chk($sformatf("dut%0d_rdata", k), (k == 0) ? rdata_a : rdata_b, e_rdata[k]);
        if (x_ack0 || x_ack1)
            $display("txn dut%0d requester=%0d addr=%h rdata=%h t=%0t",
                     k, win[k], e_addr[k], (k == 0) ? rdata_a : rdata_b, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                compare(k);
            end
        end
    end

    // which: 0 = ack0 only, 1 = ack1 only, 2 = either.
    task automatic wait_ack(input int k, input int which, input int maxc, input string tag,
                            output int cyc, output int who, output logic [3:0] data);
        bit got;
        got  = 1'b0;
        cyc  = 0;
        who  = -1;
        data = 4'h0;
        while (!got && cyc < maxc) begin
            @(posedge clk);
            #2;
            cyc++;
            if (((k == 0) ? ack0_a : ack0_b) && which != 1) begin
                got = 1'b1; who = 0;
            end else if (((k == 0) ? ack1_a : ack1_b) && which != 0) begin
                got = 1'b1; who = 1;
            end
            data = (k == 0) ? rdata_a : rdata_b;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles, required an ack", tag, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, who, rd_cnt, acks;
        logic [3:0] data;
        logic [3:0] tbl [16];

        tbl = '{4'hA, 4'h3, 4'hF, 4'h6, 4'h1, 4'hC, 4'h8, 4'h0,
                4'h5, 4'hE, 4'h2, 4'h9, 4'h7, 4'h4, 4'hB, 4'hD};
        for (int i = 0; i < 16; i++) rom[i] = tbl[i];

        rst = 1'b1;
        req0_a = 0; req1_a = 0; addr0_a = 0; addr1_a = 0;
        req0_b = 0; req1_b = 0; addr0_b = 0; addr1_b = 0;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_rom_rd", rom_rd_a, 1'b0);
        chk("rst_ack", {ack0_a, ack1_a, ack0_b, ack1_b}, 4'b0);
        chk("rst_rdata", rdata_b, 4'h0);
        @(negedge clk) rst = 1'b0;

        // Single read by requester 0
        @(negedge clk);
        req0_a = 1'b1; addr0_a = 4'h5;
        wait_ack(0, 0, 10, "t2_ack0", cyc, who, data);
        chk("t2_latency", cyc, 2);
        chk("t2_rdata", data, 4'hC);
        chk("t2_ack1_low", ack1_a, 1'b0);
        @(negedge clk) req0_a = 1'b0;
        repeat (3) @(negedge clk);

        // Contention from reset: requester 0 first, then strict alternation
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req0_a = 1'b1; addr0_a = 4'h3;
        req1_a = 1'b1; addr1_a = 4'hC;
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, 2, 10, "t3_ack", cyc, who, data);
            chk($sformatf("t3_who_%0d", i), who, i % 2);
            chk($sformatf("t3_rdata_%0d", i), data, (i % 2 == 1) ? 4'h7 : 4'h6);
            chk($sformatf("t3_gap_%0d", i), cyc, (i == 0) ? 2 : 3);
        end
        @(negedge clk);
        req0_a = 1'b0; req1_a = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back sweep by requester 1
        req1_a = 1'b1; addr1_a = 4'h0;
        for (int i = 0; i < 16; i++) begin
            wait_ack(0, 1, 10, "t4_ack1", cyc, who, data);
            chk($sformatf("t4_rdata_%0d", i), data, tbl[i]);
            chk($sformatf("t4_gap_%0d", i), cyc, (i == 0) ? 2 : 3);
            @(negedge clk);
            if (i == 15) req1_a = 1'b0;
            else         addr1_a = 4'(i + 1);
        end
        repeat (3) @(negedge clk);

        // Late request while requester 0 is in its access
        req0_a = 1'b1; addr0_a = 4'h5;
        @(posedge clk);
        @(negedge clk);
        req1_a = 1'b1; addr1_a = 4'h9;
        wait_ack(0, 0, 10, "t6_ack0", cyc, who, data);
        chk("t6_ack0_delay", cyc, 1);
        chk("t6_rdata0", data, 4'hC);
        @(negedge clk) req0_a = 1'b0;
        wait_ack(0, 1, 10, "t6_ack1", cyc, who, data);
        chk("t6_ack1_gap", cyc, 3);
        chk("t6_rdata1", data, 4'hE);
        @(negedge clk) req1_a = 1'b0;
        repeat (3) @(negedge clk);

        // Four-cycle access on the second instance
        req1_b = 1'b1; addr1_b = 4'hA;
        cyc = 0; rd_cnt = 0;
        while (!ack1_b && cyc < 20) begin
            @(posedge clk);
            #2;
            cyc++;
            if (rom_rd_b) rd_cnt++;
        end
        chk("t5_ack1_seen", ack1_b, 1'b1);
        chk("t5_latency", cyc, 5);
        chk("t5_rd_cycles", rd_cnt, 4);
        chk("t5_rdata", rdata_b, 4'h2);
        @(negedge clk) req1_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a long access: aborted, no ack afterwards
        req0_b = 1'b1; addr0_b = 4'h7;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req0_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_busy", busy_b, 1'b0);
        chk("t1_rom_rd", rom_rd_b, 1'b0);
        chk("t1_rom_address", rom_address_b, 4'h0);
        chk("t1_rdata", rdata_b, 4'h0);
        chk("t1_ack", {ack0_b, ack1_b}, 2'b00);
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(posedge clk);
            #2;
            if (ack0_b || ack1_b) acks++;
        end
        chk("t1_no_ack_after_reset", acks, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
